// File: rtl/cont_mod_updown.sv
// -----------------------------------------------------------------------------
// cont_mod_updown
//   Parametrised modulo-MODULO up/down counter with enable, synchronous clear
//   and load, and a wrap / one-shot mode. TC is combinational so that a chain
//   of counters can be built by feeding one stage's TC into the next stage's
//   enable.
//
// Parameters
//   N       counter width in bits
//   MODULO  count range 0..MODULO-1, 2 <= MODULO <= 2**N
//
// Ports
//   clk     rising-edge clock
//   reset   asynchronous reset, active-high: Q=0, done=0
//   enable  count enable
//   updown  1 = count up, 0 = count down
//   clear   synchronous clear (highest priority)
//   load    synchronous load of D (saturated to MODULO-1)
//   D       load value
//   mode    0 = wrap around, 1 = one-shot (stop at terminal, raise done)
//   Q       registered count value
//   TC      terminal count: enable & ~done & at terminal for current direction
//   done    one-shot completed flag (registered)
// -----------------------------------------------------------------------------
module cont_mod_updown #(
  parameter int N      = 4,
  parameter int MODULO = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         updown,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] D,
  input  logic         mode,
  output logic [N-1:0] Q,
  output logic         TC,
  output logic         done
);

  generate
    if (MODULO < 2 || MODULO > (1 << N)) begin : g_bad_modulo
      $error("cont_mod_updown: MODULO must satisfy 2 <= MODULO <= 2**N");
    end
  endgenerate

  // MODULO may equal 2**N, so compare loads in N+1 bits.
  localparam logic [N:0]   MOD_EXT = MODULO[N:0];
  localparam logic [N-1:0] Q_MAX   = N'(MODULO - 1);

  typedef enum logic {
    COUNT = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t       state, state_nxt;
  logic [N-1:0] q_nxt;
  logic [N-1:0] load_val;
  logic         at_term;

  assign at_term  = updown ? (Q == Q_MAX) : (Q == '0);
  assign done     = (state == DONE);
  assign TC       = enable & ~done & at_term;

  // Out-of-range load values saturate so Q never leaves 0..MODULO-1.
  assign load_val = ({1'b0, D} >= MOD_EXT) ? Q_MAX : D;

  // NOTE: every signal gets a default first so no path leaves it unassigned;
  // otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_nxt = state;
    q_nxt     = Q;
    if (clear) begin
      q_nxt     = '0;
      state_nxt = COUNT;
    end else if (load) begin
      q_nxt     = load_val;
      state_nxt = COUNT;
    end else if (enable && state == COUNT) begin
      if (at_term) begin
        if (mode) begin
          state_nxt = DONE;            // one-shot: Q holds at terminal
        end else begin
          q_nxt = updown ? '0 : Q_MAX; // wrap around
        end
      end else begin
        q_nxt = updown ? Q + 1'b1 : Q - 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COUNT;
      Q     <= '0;
    end else begin
      state <= state_nxt;
      Q     <= q_nxt;
    end
  end

endmodule

// File: tb/tb_cont_mod_updown.sv
// -----------------------------------------------------------------------------
// tb_cont_mod_updown
//   Self-checking bench for cont_mod_updown (N=4, MODULO=10): directed
//   sequences, a vector table, randomized stimulus against a behavioural model
//   and a two-stage decimal cascade.
// -----------------------------------------------------------------------------
module tb_cont_mod_updown;

  localparam int N   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable, updown, clear, load, mode;
  logic [N-1:0] D;
  logic [N-1:0] Q;
  logic         TC, done;

  // cascade stage signals
  logic         cas_en;
  logic [N-1:0] zero_d = '0;
  logic         zero   = 1'b0;
  logic         one    = 1'b1;
  logic [N-1:0] lo_q, hi_q;
  logic         lo_tc, hi_tc, lo_done, hi_done;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int m_q;
  bit m_done;

  always #5 clk = ~clk;

  cont_mod_updown #(.N(N), .MODULO(MOD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .updown(updown),
    .clear(clear), .load(load), .D(D), .mode(mode),
    .Q(Q), .TC(TC), .done(done)
  );

  cont_mod_updown #(.N(N), .MODULO(MOD)) u_lo (
    .clk(clk), .reset(reset), .enable(cas_en), .updown(one),
    .clear(zero), .load(zero), .D(zero_d), .mode(zero),
    .Q(lo_q), .TC(lo_tc), .done(lo_done)
  );

  cont_mod_updown #(.N(N), .MODULO(MOD)) u_hi (
    .clk(clk), .reset(reset), .enable(lo_tc), .updown(one),
    .clear(zero), .load(zero), .D(zero_d), .mode(zero),
    .Q(hi_q), .TC(hi_tc), .done(hi_done)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec-level model of one rising edge.
  function automatic void model_step(input bit clr, input bit ld, input bit en,
                                     input bit up, input bit md, input int d);
    int nxt;
    if (clr) begin
      m_q = 0; m_done = 0;
    end else if (ld) begin
      m_q = (d >= MOD) ? MOD - 1 : d;
      m_done = 0;
    end else if (en && !m_done) begin
      nxt = up ? m_q + 1 : m_q - 1;
      if (md && (nxt < 0 || nxt >= MOD)) m_done = 1;
      else m_q = (nxt + MOD) % MOD;
    end
  endfunction

  function automatic bit model_tc(input bit en, input bit up);
    return en && !m_done && (up ? (m_q == MOD - 1) : (m_q == 0));
  endfunction

  typedef struct {
    logic       clr, ld, en, up, md;
    logic [3:0] d;
    int         q;
    bit         dn;
    bit         tc;
  } vec_t;

  vec_t vecs[15];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ------------------------------------------------ reset state
    reset = 1'b1; enable = 1'b1; updown = 1'b1; clear = 1'b0; load = 1'b0;
    mode = 1'b0; D = '0; cas_en = 1'b0;
    #12;
    check("reset_q", Q, 0);
    check("reset_done", done, 0);
    check("reset_tc", TC, 0);
    enable = 1'b0;
    @(negedge clk); reset = 1'b0;
    tick();

    // ------------------------------------------------ 1: async reset mid-cycle
    load = 1'b1; D = 4'd6; tick(); load = 1'b0;
    check("t1_loaded6", Q, 6);
    enable = 1'b1; updown = 1'b1; mode = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t1_async_q", Q, 0);
    check("t1_async_done", done, 0);
    tick();
    check("t1_held_q", Q, 0);
    #2 reset = 1'b0;
    tick();
    check("t1_first_count", Q, 1);

    // ------------------------------------------------ 2: wrap up, drop enable
    enable = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
    enable = 1'b1; updown = 1'b1; mode = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("t2_up_q", Q, i);
      if (i == 9) check("t2_tc_at9", TC, 1);
    end
    tick();
    check("t2_wrap_q", Q, 0);
    check("t2_wrap_tc", TC, 0);
    repeat (4) tick();
    enable = 1'b0;
    #1;
    check("t2_tc_en0", TC, 0);
    tick();
    check("t2_hold_q", Q, 4);

    // ------------------------------------------------ 3: down wrap, flip dir
    clear = 1'b1; tick(); clear = 1'b0;
    enable = 1'b1; updown = 1'b0;
    #1;
    check("t3_tc_down0", TC, 1);
    tick();
    check("t3_wrap_down_q", Q, 9);
    check("t3_tc_down9", TC, 0);
    updown = 1'b1;
    #1;
    check("t3_tc_flip", TC, 1);
    tick();
    check("t3_after_flip_q", Q, 0);

    // ------------------------------------------------ 5: one-shot
    load = 1'b1; D = 4'd7; tick(); load = 1'b0;
    mode = 1'b1; enable = 1'b1; updown = 1'b1;
    tick(); check("t5_q8", Q, 8);
    tick(); check("t5_q9", Q, 9);
    check("t5_tc_pre_done", TC, 1);
    tick();
    check("t5_done_q", Q, 9);
    check("t5_done", done, 1);
    check("t5_done_tc", TC, 0);
    mode = 1'b0; updown = 1'b0;
    repeat (3) tick();
    check("t5_frozen_q", Q, 9);
    check("t5_mode_no_release", done, 1);
    check("t5_frozen_tc", TC, 0);
    updown = 1'b1; mode = 1'b1;
    load = 1'b1; D = 4'd3; tick(); load = 1'b0;
    check("t5_reload_q", Q, 3);
    check("t5_reload_done", done, 0);
    tick();
    check("t5_resume_q", Q, 4);

    // ------------------------------------------------ table-driven vectors
    vecs[0]  = '{clr:0, ld:1, en:1, up:1, md:0, d:4'd7,  q:7, dn:0, tc:0};
    vecs[1]  = '{clr:0, ld:1, en:1, up:1, md:0, d:4'd12, q:9, dn:0, tc:1};
    vecs[2]  = '{clr:1, ld:1, en:1, up:1, md:0, d:4'd5,  q:0, dn:0, tc:0};
    vecs[3]  = '{clr:0, ld:0, en:1, up:0, md:0, d:4'd0,  q:9, dn:0, tc:0};
    vecs[4]  = '{clr:0, ld:0, en:1, up:1, md:0, d:4'd0,  q:0, dn:0, tc:0};
    vecs[5]  = '{clr:0, ld:0, en:0, up:1, md:0, d:4'd0,  q:0, dn:0, tc:0};
    vecs[6]  = '{clr:0, ld:1, en:0, up:1, md:0, d:4'd9,  q:9, dn:0, tc:0};
    vecs[7]  = '{clr:0, ld:0, en:1, up:1, md:1, d:4'd0,  q:9, dn:1, tc:0};
    vecs[8]  = '{clr:0, ld:0, en:1, up:1, md:0, d:4'd0,  q:9, dn:1, tc:0};
    vecs[9]  = '{clr:0, ld:0, en:1, up:0, md:0, d:4'd0,  q:9, dn:1, tc:0};
    vecs[10] = '{clr:0, ld:1, en:1, up:0, md:0, d:4'd15, q:9, dn:0, tc:0};
    vecs[11] = '{clr:0, ld:0, en:1, up:0, md:0, d:4'd0,  q:8, dn:0, tc:0};
    vecs[12] = '{clr:0, ld:1, en:1, up:0, md:1, d:4'd0,  q:0, dn:0, tc:1};
    vecs[13] = '{clr:0, ld:0, en:1, up:0, md:1, d:4'd0,  q:0, dn:1, tc:0};
    vecs[14] = '{clr:1, ld:0, en:1, up:1, md:0, d:4'd0,  q:0, dn:0, tc:0};

    enable = 1'b0; load = 1'b0; clear = 1'b1; tick();
    for (int i = 0; i < 15; i++) begin
      clear = vecs[i].clr; load = vecs[i].ld; enable = vecs[i].en;
      updown = vecs[i].up; mode = vecs[i].md; D = vecs[i].d;
      tick();
      check($sformatf("vec%0d_q", i), Q, vecs[i].q);
      check($sformatf("vec%0d_done", i), done, vecs[i].dn);
      check($sformatf("vec%0d_tc", i), TC, vecs[i].tc);
    end

    // ------------------------------------------------ random vs model
    clear = 1'b1; load = 1'b0; enable = 1'b0; tick();
    m_q = 0; m_done = 0;
    for (int i = 0; i < 300; i++) begin
      clear  = ($urandom_range(15) == 0);
      load   = ($urandom_range(7) == 0);
      enable = ($urandom_range(3) != 0);
      updown = $urandom_range(1);
      mode   = ($urandom_range(3) == 0);
      D      = N'($urandom_range(15));
      #1;
      check("rand_tc", TC, model_tc(enable, updown));
      model_step(clear, load, enable, updown, mode, int'(D));
      tick();
      check("rand_q", Q, m_q);
      check("rand_done", done, m_done);
    end
    clear = 1'b0; load = 1'b0; enable = 1'b0;

    // ------------------------------------------------ 6: decimal cascade
    begin : cascade
      int cnt;
      reset = 1'b1; #3; reset = 1'b0;
      cnt = 0;
      cas_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
        tick();
        cnt = (cnt + 1) % 100;
        check("cas_seq", int'(hi_q) * 10 + int'(lo_q), cnt);
      end
      for (int i = 0; i < 200; i++) begin
        cas_en = $urandom_range(1);
        tick();
        if (cas_en) cnt = (cnt + 1) % 100;
        check("cas_rand", int'(hi_q) * 10 + int'(lo_q), cnt);
      end
      // force a 99 -> 00 rollover check
      cas_en = 1'b1;
      while (cnt != 99) begin
        tick();
        cnt = (cnt + 1) % 100;
      end
      check("cas_at99", int'(hi_q) * 10 + int'(lo_q), 99);
      tick();
      check("cas_rollover", int'(hi_q) * 10 + int'(lo_q), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
